// File: rtl/ad9280_scope_pkg.sv
// Shared constants for the AD9280 scope stream packer: state encoding, lane geometry
// and the tkeep lookup used when a word closes with fewer than LANES samples.
package ad9280_scope_pkg;

   localparam int SAMPLE_WIDTH = 8;
   localparam int LANES        = 4;
   localparam int OUT_WIDTH    = SAMPLE_WIDTH * LANES;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t RUN   = 2'd1;
   localparam state_t DRAIN = 2'd2;
   localparam state_t DONE  = 2'd3;

   // n = number of populated byte lanes (1..LANES); lanes fill from bit 0 upward.
   function automatic logic [LANES-1:0] keep_from_lanes(input logic [2:0] n);
      logic [LANES-1:0] k;
      k = '0;
      for (int i = 0; i < LANES; i++) begin
         if (i < int'(n)) k[i] = 1'b1;
      end
      return k;
   endfunction

endpackage

// File: rtl/scope_axis_out_stage.sv
// Single-entry AXI-Stream register: loads a packed word, holds it stable until ready,
// and empties on handshake. clear_i drops the entry unconditionally.
module scope_axis_out_stage #(
   parameter int DATA_W = 32,
   parameter int KEEP_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [KEEP_W-1:0] keep_i,
   input  logic              last_i,
   input  logic              ready_i,
   output logic [DATA_W-1:0] tdata_o,
   output logic [KEEP_W-1:0] tkeep_o,
   output logic              tlast_o,
   output logic              tvalid_o
);

   logic [DATA_W-1:0] tdata_q, tdata_d;
   logic [KEEP_W-1:0] tkeep_q, tkeep_d;
   logic              tlast_q, tlast_d;
   logic              tvalid_q, tvalid_d;

   // The producer only loads when the entry is empty or draining this cycle.
   always_comb begin
      tdata_d  = tdata_q;
      tkeep_d  = tkeep_q;
      tlast_d  = tlast_q;
      tvalid_d = tvalid_q;
      if (clear_i) begin
         tdata_d  = '0;
         tkeep_d  = '0;
         tlast_d  = 1'b0;
         tvalid_d = 1'b0;
      end else if (load_i) begin
         tdata_d  = data_i;
         tkeep_d  = keep_i;
         tlast_d  = last_i;
         tvalid_d = 1'b1;
      end else if (tvalid_q && ready_i) begin
         tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tdata_q  <= '0;
         tkeep_q  <= '0;
         tlast_q  <= 1'b0;
         tvalid_q <= 1'b0;
      end else begin
         tdata_q  <= tdata_d;
         tkeep_q  <= tkeep_d;
         tlast_q  <= tlast_d;
         tvalid_q <= tvalid_d;
      end
   end

   assign tdata_o  = tdata_q;
   assign tkeep_o  = tkeep_q;
   assign tlast_o  = tlast_q;
   assign tvalid_o = tvalid_q;

endmodule

// File: rtl/ad9280_scope_stream_packer.sv
// Packs frame_len 8-bit ADC samples per armed frame, 4 per word little-endian, onto AXI-Stream.
// Optional decimation (keep 1 of every decim_factor+1 samples) when SCOPE_PACK_DECIM_EN is defined.
module ad9280_scope_stream_packer
   import ad9280_scope_pkg::*;
#(
   parameter int SAMPLE_WIDTH    = 8,
   parameter int LANES           = 4,
   parameter int FRAME_LEN_WIDTH = 16
) (
   input  logic                            sys_clk,
   input  logic                            sys_rst,
   input  logic                            s_valid,
   input  logic [SAMPLE_WIDTH-1:0]         s_data,
   output logic                            s_ready,
   input  logic                            start,
   input  logic                            abort,
   input  logic [FRAME_LEN_WIDTH-1:0]      frame_len,
`ifdef SCOPE_PACK_DECIM_EN
   input  logic [7:0]                      decim_factor,
`endif
   output logic [SAMPLE_WIDTH*LANES-1:0]   m_axis_tdata,
   output logic [LANES-1:0]                m_axis_tkeep,
   output logic                            m_axis_tlast,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            busy,
   output logic                            done
);

   localparam int IDX_W = $clog2(LANES);
   localparam int W     = SAMPLE_WIDTH * LANES;

   state_t                     state_q, state_d;
   logic [FRAME_LEN_WIDTH-1:0] remaining_q, remaining_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [W-1:0]               pack_q, pack_d;
   logic [W-1:0]               word_w;
   logic                       take_w, last_w, completes_w, accept_w, keep_w, load_w, start_w;

`ifdef SCOPE_PACK_DECIM_EN
   logic [7:0] decim_factor_q, decim_factor_d;
   logic [7:0] decim_cnt_q, decim_cnt_d;
   assign take_w = (decim_cnt_q == 8'd0);
`else
   assign take_w = 1'b1;
`endif

   assign start_w     = (state_q == IDLE) && start && (frame_len != '0) && !abort;
   assign last_w      = (remaining_q == FRAME_LEN_WIDTH'(1));
   assign completes_w = take_w && ((idx_q == IDX_W'(LANES - 1)) || last_w);
   assign accept_w    = s_valid && s_ready;
   assign keep_w      = accept_w && take_w;
   assign load_w      = keep_w && completes_w && !abort;

   // Lanes above idx are still zero because the pack register is cleared on every word close.
   always_comb begin
      word_w = pack_q;
      word_w[32'(idx_q) * SAMPLE_WIDTH +: SAMPLE_WIDTH] = s_data;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_w) state_d = RUN;
         RUN:     if (keep_w && last_w) state_d = DRAIN;
         DRAIN:   if (m_axis_tvalid && m_axis_tready) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   // A closing sample may pass only if the output entry is free or emptying this cycle.
   always_comb begin
      s_ready = (state_q == RUN) && (!completes_w || !m_axis_tvalid || m_axis_tready);
      busy    = (state_q == RUN) || (state_q == DRAIN);
      done    = (state_q == DONE);
   end

   always_comb begin
      remaining_d = remaining_q;
      idx_d       = idx_q;
      pack_d      = pack_q;
      if (abort) begin
         remaining_d = '0;
         idx_d       = '0;
         pack_d      = '0;
      end else if (start_w) begin
         remaining_d = frame_len;
         idx_d       = '0;
         pack_d      = '0;
      end else if (keep_w) begin
         remaining_d = remaining_q - FRAME_LEN_WIDTH'(1);
         if (completes_w) begin
            idx_d  = '0;
            pack_d = '0;
         end else begin
            idx_d  = idx_q + IDX_W'(1);
            pack_d = word_w;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         remaining_q <= '0;
         idx_q       <= '0;
         pack_q      <= '0;
      end else begin
         remaining_q <= remaining_d;
         idx_q       <= idx_d;
         pack_q      <= pack_d;
      end
   end

`ifdef SCOPE_PACK_DECIM_EN
   // Discarded samples still advance the phase counter; the first sample of a frame is kept.
   always_comb begin
      decim_factor_d = decim_factor_q;
      decim_cnt_d    = decim_cnt_q;
      if (abort) begin
         decim_cnt_d = '0;
      end else if (start_w) begin
         decim_factor_d = decim_factor;
         decim_cnt_d    = '0;
      end else if (accept_w) begin
         decim_cnt_d = (decim_cnt_q == decim_factor_q) ? 8'd0 : decim_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         decim_factor_q <= '0;
         decim_cnt_q    <= '0;
      end else begin
         decim_factor_q <= decim_factor_d;
         decim_cnt_q    <= decim_cnt_d;
      end
   end
`endif

   scope_axis_out_stage #(
      .DATA_W (W),
      .KEEP_W (LANES)
   ) u_out_stage (
      .clk_i    (sys_clk),
      .rst_i    (sys_rst),
      .clear_i  (abort),
      .load_i   (load_w),
      .data_i   (word_w),
      .keep_i   (keep_from_lanes(3'(idx_q) + 3'd1)),
      .last_i   (last_w),
      .ready_i  (m_axis_tready),
      .tdata_o  (m_axis_tdata),
      .tkeep_o  (m_axis_tkeep),
      .tlast_o  (m_axis_tlast),
      .tvalid_o (m_axis_tvalid)
   );

endmodule

// File: tb/tb_ad9280_scope_stream_packer.sv
// Scoreboard bench for ad9280_scope_stream_packer: frames are modelled as sample lists,
// chopped into 4-byte words, and compared by a negedge monitor on every AXIS handshake.
module tb_ad9280_scope_stream_packer;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        start;
   logic        abort;
   logic [15:0] frame_len;
`ifdef SCOPE_PACK_DECIM_EN
   logic [7:0]  decim_factor;
`endif
   logic [31:0] m_axis_tdata;
   logic [3:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        busy;
   logic        done;

   always #5 sys_clk = ~sys_clk;

   ad9280_scope_stream_packer dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .s_valid       (s_valid),
      .s_data        (s_data),
      .s_ready       (s_ready),
      .start         (start),
      .abort         (abort),
      .frame_len     (frame_len),
`ifdef SCOPE_PACK_DECIM_EN
      .decim_factor  (decim_factor),
`endif
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .done          (done)
   );

   int          n_vec = 0;
   int          n_err = 0;
   int          done_cnt = 0;
   int          tready_mode = 0;   // 0: always 1, 1: random, 2: driven by the test
   bit          mon_en = 0;
   bit          last_hs = 0;
   bit          hold_pend = 0;
   logic [36:0] hold_word;
   logic [36:0] exp_q[$];          // {tlast, tkeep, tdata}

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // Monitor: every negedge, handshakes pop the scoreboard; done must trail a tlast handshake by one cycle.
   always @(negedge sys_clk) begin
      if (mon_en) begin
         logic [36:0] cur;
         cur = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
         check("done_after_tlast", 40'(done), 40'(last_hs));
         if (hold_pend) check("axis_hold", 40'({m_axis_tvalid, cur}), 40'({1'b1, hold_word}));
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_word: got %h expected none", cur);
            end else begin
               check("word", 40'(cur), 40'(exp_q.pop_front()));
            end
         end
         if (done) done_cnt++;
         last_hs   = m_axis_tvalid && m_axis_tready && m_axis_tlast;
         hold_pend = m_axis_tvalid && !m_axis_tready;
         hold_word = cur;
      end
   end

   always @(posedge sys_clk) begin
      #1;
      case (tready_mode)
         0:       m_axis_tready = 1'b1;
         1:       m_axis_tready = 1'($urandom_range(0, 1));
         default: ;
      endcase
   end

   // Reference model: keep every (d+1)-th sample, then cut the kept list into 4-byte words.
   task automatic push_expected(input logic [7:0] kept[$]);
      int n;
      n = kept.size();
      for (int w = 0; w * 4 < n; w++) begin
         logic [31:0] data;
         int used;
         data = 32'h0;
         used = 0;
         for (int k = 0; k < 4 && w * 4 + k < n; k++) begin
            data = data | (32'(kept[w * 4 + k]) << (8 * k));
            used++;
         end
         exp_q.push_back({(w * 4 + 4 >= n), 4'((1 << used) - 1), data});
      end
   endtask

   task automatic send_sample(input logic [7:0] d, input int gap_max);
      int t;
      t = 0;
      repeat ($urandom_range(0, gap_max)) begin
         @(posedge sys_clk);
         #1;
      end
      s_valid = 1'b1;
      s_data  = d;
      while (1) begin
         @(negedge sys_clk);
         if (s_ready === 1'b1) break;
         t++;
         if (t > 500) begin
            fail("s_ready_timeout");
            break;
         end
      end
      @(posedge sys_clk);
      #1;
      s_valid = 1'b0;
      s_data  = 8'($urandom);
   endtask

   task automatic pulse_start(input int len, input int d);
      @(posedge sys_clk);
      #1;
      start     = 1'b1;
      frame_len = 16'(len);
`ifdef SCOPE_PACK_DECIM_EN
      decim_factor = 8'(d);
`endif
      @(posedge sys_clk);
      #1;
      start     = 1'b0;
      frame_len = 16'($urandom);
   endtask

   // base < 0 gives random sample values; otherwise samples count up from base.
   task automatic run_frame(input int len, input int d, input int gap_max, input int base);
      logic [7:0] smp_q[$];
      logic [7:0] kept[$];
      int total;
      int t;
      int done0;
      total = (len - 1) * (d + 1) + 1;
      for (int i = 0; i < total; i++) smp_q.push_back(base < 0 ? 8'($urandom) : 8'(base + i));
      for (int i = 0; i < total; i += d + 1) kept.push_back(smp_q[i]);
      push_expected(kept);
      done0 = done_cnt;
      pulse_start(len, d);
      foreach (smp_q[i]) send_sample(smp_q[i], gap_max);
      @(negedge sys_clk);
      check("drain_s_ready", 40'(s_ready), 40'(0));
      check("drain_busy", 40'(busy), 40'(1));
      t = 0;
      while (done_cnt == done0 && t < 1000) begin
         @(negedge sys_clk);
         t++;
      end
      if (done_cnt == done0) fail("done_timeout");
      check("done_count", 40'(done_cnt - done0), 40'(1));
   endtask

   initial begin
      int t;
      int d0;
      sys_rst = 1'b1;
      s_valid = 1'b0;
      s_data = 8'h0;
      start = 1'b0;
      abort = 1'b0;
      frame_len = 16'h0;
`ifdef SCOPE_PACK_DECIM_EN
      decim_factor = 8'h0;
`endif
      tready_mode = 2;
      m_axis_tready = 1'b0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      check("rst_tvalid", 40'(m_axis_tvalid), 40'(0));
      check("rst_tdata", 40'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 40'(0));
      check("rst_flags", 40'({busy, done, s_ready}), 40'(0));
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      mon_en = 1;
      tready_mode = 0;

      run_frame(8, 0, 0, 1);
      run_frame(6, 0, 0, 1);

      @(posedge sys_clk);
      #1;
      tready_mode = 2;
      m_axis_tready = 1'b0;
      fork
         run_frame(12, 0, 0, 8'h10);
         begin
            t = 0;
            while (m_axis_tvalid !== 1'b1 && t < 200) begin
               @(negedge sys_clk);
               t++;
            end
            if (m_axis_tvalid !== 1'b1) fail("first_word_timeout");
            repeat (10) @(negedge sys_clk);
            check("bp_s_ready", 40'(s_ready), 40'(0));
            check("bp_tvalid", 40'(m_axis_tvalid), 40'(1));
            @(posedge sys_clk);
            #1;
            m_axis_tready = 1'b1;
            tready_mode = 0;
         end
      join

      d0 = done_cnt;
      pulse_start(8, 0);
      for (int i = 0; i < 3; i++) send_sample(8'hA0 + 8'(i), 0);
      abort = 1'b1;
      @(posedge sys_clk);
      #1;
      abort = 1'b0;
      @(negedge sys_clk);
      check("abort_tvalid", 40'(m_axis_tvalid), 40'(0));
      check("abort_busy", 40'(busy), 40'(0));
      repeat (5) @(negedge sys_clk);
      check("abort_no_done", 40'(done_cnt), 40'(d0));
      run_frame(4, 0, 0, 8'h41);

      pulse_start(0, 0);
      repeat (4) begin
         @(negedge sys_clk);
         check("zero_len_idle", 40'({busy, s_ready, m_axis_tvalid}), 40'(0));
      end
      fork
         run_frame(8, 0, 1, 8'h20);
         begin
            repeat (4) @(posedge sys_clk);
            #1;
            start = 1'b1;
            frame_len = 16'd3;
            @(posedge sys_clk);
            #1;
            start = 1'b0;
         end
      join

`ifdef SCOPE_PACK_DECIM_EN
      run_frame(4, 1, 0, 0);
`endif

      tready_mode = 1;
      for (int f = 0; f < 25; f++) begin
`ifdef SCOPE_PACK_DECIM_EN
         run_frame($urandom_range(1, 20), $urandom_range(0, 3), 2, -1);
`else
         run_frame($urandom_range(1, 20), 0, 2, -1);
`endif
      end
      tready_mode = 0;
      repeat (5) @(negedge sys_clk);
      check("leftover_words", 40'(exp_q.size()), 40'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      n_err++;
      $display("FAIL watchdog: simulation did not complete at %0t", $time);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

endmodule
